// File: rtl/simple_arith_pkg.sv
// simple_arith_pkg
// Shared types and constants for the simple_arith_core engine and the
// register-bank opcode decode.
//   OPC_*     : opcode encodings as seen on cmd_op
//   op_t      : typed opcode
//   state_t   : controller state
//   op_is_iter: true when an opcode needs the multi-cycle datapath
package simple_arith_pkg;

    localparam logic [1:0] OPC_ADD  = 2'd0;
    localparam logic [1:0] OPC_SUB  = 2'd1;
    localparam logic [1:0] OPC_MUL  = 2'd2;
    localparam logic [1:0] OPC_DIVU = 2'd3;

    typedef enum logic [1:0] {
        OP_ADD  = OPC_ADD,
        OP_SUB  = OPC_SUB,
        OP_MUL  = OPC_MUL,
        OP_DIVU = OPC_DIVU
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Divide by zero is answered immediately, so it never iterates.
    function automatic logic op_is_iter(input op_t op, input logic b_zero);
        return (op == OP_MUL) || ((op == OP_DIVU) && !b_zero);
    endfunction

endpackage

// File: rtl/simple_arith_iter.sv
// simple_arith_iter
// Iterative datapath: unsigned shift-add multiply (LSB of B first) and
// restoring divide (MSB of A first), one bit per step.
//   ACLK, ARESET : clock, async active-high reset
//   load         : capture operands and clear the accumulator
//   step         : perform one iteration
//   is_div       : at load, selects divide (1) or multiply (0)
//   op_a, op_b   : operands (A multiplicand/dividend, B multiplier/divisor)
//   acc_hi_nxt   : high accumulator word after the current step
//   acc_lo_nxt   : low accumulator word after the current step
// The outputs are the post-step accumulator so the controller can capture
// the final result on the same edge as the last iteration.
module simple_arith_iter
    import simple_arith_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  load,
    input  logic                  step,
    input  logic                  is_div,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic [DATA_WIDTH-1:0] acc_hi_nxt,
    output logic [DATA_WIDTH-1:0] acc_lo_nxt
);

    // Multiply: hi = partial product, lo = remaining multiplier bits,
    //           shifted right together each step.
    // Divide:   hi = partial remainder, lo = dividend bits shifting out
    //           the top while quotient bits shift in at the bottom.
    logic [DATA_WIDTH-1:0] hi_q, hi_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;
    logic [DATA_WIDTH-1:0] m_q,  m_d;
    logic                  div_q, div_d;

    logic [DATA_WIDTH:0]   mul_sum;
    logic [DATA_WIDTH-1:0] mul_hi, mul_lo;
    logic [DATA_WIDTH:0]   div_shift;
    logic                  div_fit;
    logic [DATA_WIDTH-1:0] div_diff;
    logic [DATA_WIDTH-1:0] div_hi, div_lo;

    always_comb begin
        // Carry out of the add is kept so A*B with all-ones operands fits.
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        mul_hi  = mul_sum[DATA_WIDTH:1];
        mul_lo  = {mul_sum[0], lo_q[DATA_WIDTH-1:1]};

        div_shift = {hi_q, lo_q[DATA_WIDTH-1]};
        div_fit   = (div_shift >= {1'b0, m_q});
        // When it fits, the true difference is below the divisor, so the
        // low DATA_WIDTH bits of the subtraction are exact.
        div_diff  = div_shift[DATA_WIDTH-1:0] - m_q;
        div_hi    = div_fit ? div_diff : div_shift[DATA_WIDTH-1:0];
        div_lo    = {lo_q[DATA_WIDTH-2:0], div_fit};

        acc_hi_nxt = div_q ? div_hi : mul_hi;
        acc_lo_nxt = div_q ? div_lo : mul_lo;
    end

    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        m_d   = m_q;
        div_d = div_q;
        if (load) begin
            hi_d  = '0;
            lo_d  = is_div ? op_a : op_b;
            m_d   = is_div ? op_b : op_a;
            div_d = is_div;
        end else if (step) begin
            hi_d = acc_hi_nxt;
            lo_d = acc_lo_nxt;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            hi_q  <= '0;
            lo_q  <= '0;
            m_q   <= '0;
            div_q <= 1'b0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            m_q   <= m_d;
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/simple_arith_core.sv
// simple_arith_core
// Multi-cycle integer engine behind the SimpleArithmeticAXI register bank.
// ADD/SUB and divide-by-zero answer in one cycle; MUL and DIVU iterate
// DATA_WIDTH times in simple_arith_iter.
//   ACLK, ARESET          : clock, async active-high reset
//   cmd_valid/cmd_ready   : command handshake
//   cmd_op, cmd_a, cmd_b  : opcode and operands, captured on accept
//   res_valid/res_ready   : result handshake
//   res_lo, res_hi        : result words (held after the handshake)
//   flag_dz               : current result is a divide by zero
//   busy                  : command accepted, result not yet consumed
//
// state   | meaning
// --------+--------------------------------------------------------
// IDLE    | ready for a command
// CALC    | iterating, counter counts DATA_WIDTH down to 0
// DONE    | result valid, waiting for res_ready
module simple_arith_core
    import simple_arith_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_a,
    input  logic [DATA_WIDTH-1:0] cmd_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_lo,
    output logic [DATA_WIDTH-1:0] res_hi,
    output logic                  flag_dz,
    output logic                  busy
);

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] res_lo_q, res_lo_d;
    logic [DATA_WIDTH-1:0] res_hi_q, res_hi_d;
    logic                  flag_dz_q, flag_dz_d;

    op_t                   op;
    logic                  accept;
    logic                  b_zero;
    logic [DATA_WIDTH:0]   add_sum;
    logic [DATA_WIDTH:0]   sub_diff;
    logic                  iter_load;
    logic                  iter_step;
    logic                  iter_is_div;
    logic [DATA_WIDTH-1:0] acc_hi_nxt;
    logic [DATA_WIDTH-1:0] acc_lo_nxt;

    assign op          = op_t'(cmd_op);
    assign accept      = cmd_valid && (state_q == ST_IDLE);
    assign b_zero      = (cmd_b == '0);
    assign add_sum     = {1'b0, cmd_a} + {1'b0, cmd_b};
    // Top bit of the widened subtraction is the borrow (A < B).
    assign sub_diff    = {1'b0, cmd_a} - {1'b0, cmd_b};
    assign iter_is_div = (op == OP_DIVU);

    simple_arith_iter #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_iter (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .load      (iter_load),
        .step      (iter_step),
        .is_div    (iter_is_div),
        .op_a      (cmd_a),
        .op_b      (cmd_b),
        .acc_hi_nxt(acc_hi_nxt),
        .acc_lo_nxt(acc_lo_nxt)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        res_lo_d  = res_lo_q;
        res_hi_d  = res_hi_q;
        flag_dz_d = flag_dz_q;
        iter_load = 1'b0;
        iter_step = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    flag_dz_d = 1'b0;
                    if (op_is_iter(op, b_zero)) begin
                        iter_load = 1'b1;
                        cnt_d     = CNT_WIDTH'(DATA_WIDTH);
                        state_d   = ST_CALC;
                    end else begin
                        state_d = ST_DONE;
                        case (op)
                            OP_ADD: begin
                                res_lo_d = add_sum[DATA_WIDTH-1:0];
                                res_hi_d = {{(DATA_WIDTH-1){1'b0}}, add_sum[DATA_WIDTH]};
                            end
                            OP_SUB: begin
                                res_lo_d = sub_diff[DATA_WIDTH-1:0];
                                res_hi_d = {{(DATA_WIDTH-1){1'b0}}, sub_diff[DATA_WIDTH]};
                            end
                            default: begin
                                // Only DIVU by zero reaches here.
                                res_lo_d  = '1;
                                res_hi_d  = cmd_a;
                                flag_dz_d = 1'b1;
                            end
                        endcase
                    end
                end
            end
            ST_CALC: begin
                iter_step = 1'b1;
                cnt_d     = cnt_q - 1'b1;
                // Final iteration: capture the post-step accumulator now so
                // the result appears as the counter hits zero.
                if (cnt_q == CNT_WIDTH'(1)) begin
                    res_lo_d = acc_lo_nxt;
                    res_hi_d = acc_hi_nxt;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            res_lo_q  <= '0;
            res_hi_q  <= '0;
            flag_dz_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            res_lo_q  <= res_lo_d;
            res_hi_q  <= res_hi_d;
            flag_dz_q <= flag_dz_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign res_valid = (state_q == ST_DONE);
    assign res_lo    = res_lo_q;
    assign res_hi    = res_hi_q;
    assign flag_dz   = flag_dz_q;

endmodule

// File: doc/simple_arith_core.md
Name: simple_arith_core

Overview:
- Multi-cycle integer arithmetic engine that sits directly behind the SimpleArithmeticAXI AXI4-Lite register bank.
- The register bank writes operands A, B and an opcode, pulses a command, and later reads back the 64-bit result and status.
- Supports single-cycle ADD and SUB, and iterative unsigned MUL and DIVU.
- Uses a valid/ready command handshake and a valid/ready result handshake, so the register bank can poll or stall.

Parameters:
- DATA_WIDTH, 32, operand width in bits. Must be ≥4 and even.
- CNT_WIDTH, $clog2(DATA_WIDTH)+1, width of the iteration counter.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  core can accept a command.
- cmd_op  in  2  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIVU.
- cmd_a  in  DATA_WIDTH  operand A (dividend, minuend).
- cmd_b  in  DATA_WIDTH  operand B (divisor, subtrahend).
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_lo  out  DATA_WIDTH  low word: sum, difference, product low, or quotient.
- res_hi  out  DATA_WIDTH  high word: carry/borrow in bit 0 for ADD/SUB, product high, or remainder.
- flag_dz  out  1  divide by zero on the current result.
- busy  out  1  a command has been accepted and its result is not yet consumed.

Behaviour:
- Reset (async assert, sync release): state=IDLE; cmd_ready=1, res_valid=0, res_lo=0, res_hi=0, flag_dz=0, busy=0, counter=0.
- A command is accepted when cmd_valid&&cmd_ready on a rising edge. Operands and opcode are latched at that edge and later changes on cmd_* are ignored.
- cmd_ready = (state==IDLE). No command is accepted while CALC or DONE.
- busy = (state!=IDLE).
- States: IDLE, CALC, DONE.
- IDLE→DONE on accept of ADD, SUB, or DIVU with B==0. res_valid rises on the next cycle, so latency is 1.
- IDLE→CALC on accept of MUL, or DIVU with B!=0. The counter loads DATA_WIDTH.
- CALC: one iteration per cycle; the counter decrements. On the cycle the counter reaches 0 the state goes to DONE. res_valid rises exactly DATA_WIDTH+1 cycles after accept.
- DONE: res_valid=1 and result outputs are stable until res_valid&&res_ready. On that edge: res_valid=0, state=IDLE, cmd_ready=1 on the next cycle. Result registers keep their values after the handshake.
- res_ready is ignored outside DONE. Asserting it early has no effect.
- ADD: {res_hi[0],res_lo} = A+B, width DATA_WIDTH+1. res_hi[DATA_WIDTH-1:1]=0.
- SUB: res_lo = A−B mod 2^DATA_WIDTH. res_hi[0] = borrow (A<B), other bits 0.
- MUL: unsigned shift-add into a 2·DATA_WIDTH accumulator, one bit of B per cycle, LSB first. {res_hi,res_lo} = A·B.
- DIVU: restoring division, one quotient bit per cycle, MSB first. res_lo = quotient, res_hi = remainder.
- DIVU with B==0: res_lo = all ones, res_hi = A, flag_dz=1.
- flag_dz is cleared on any newly accepted command that is not a divide by zero.
- Reset asserted mid-CALC or mid-DONE aborts immediately. All outputs return to their reset values and the partial result is discarded.
- Corner operands: MUL by 0 still takes the full latency. MUL with A=B=2^DATA_WIDTH−1 must not overflow the accumulator. DIVU with A<B gives quotient 0, remainder A.

Decomposition:
- simple_arith_pkg:
  - op_t enum (OP_ADD, OP_SUB, OP_MUL, OP_DIVU), 2 bits.
  - state_t enum (ST_IDLE, ST_CALC, ST_DONE).
  - Localparams for opcode encodings shared with the register-bank decode.
- One sub-module, simple_arith_iter: the shift-add / restoring-divide datapath.
  - Inputs: load, step, is_div, operands.
  - Outputs: the hi/lo accumulator.
  - The top holds the FSM, counter, handshakes, and the ADD/SUB path.

Test Plan:
- ADD: A=0xFFFFFFFF, B=0x00000002, cmd_valid one cycle → res_valid one cycle later; res_lo=0x00000001, res_hi=0x00000001, flag_dz=0.
- SUB: A=0x00000003, B=0x00000005 → res_lo=0xFFFFFFFE, res_hi=0x00000001 (borrow); then res_ready=1 → cmd_ready=1 on the next cycle.
- MUL: A=0xFFFFFFFF, B=0xFFFFFFFF → res_valid exactly 33 cycles after accept; res_hi=0xFFFFFFFE, res_lo=0x00000001. cmd_valid held high during CALC is not accepted (cmd_ready=0).
- DIVU: A=100, B=7 → after 33 cycles res_lo=14, res_hi=2. Then A=5, B=0 → 1 cycle, res_lo=0xFFFFFFFF, res_hi=5, flag_dz=1. Then ADD 1+1 → flag_dz=0.
- Backpressure: MUL 3×4 with res_ready=0 for 10 cycles after res_valid → outputs stable (res_lo=12) and busy=1 throughout; handshake then returns to IDLE.
- Reset mid-operation: ARESET asserted 10 cycles into a DIVU, asynchronously between edges → res_valid, busy, res_lo, res_hi, flag_dz all 0 immediately, cmd_ready=1. A following ADD 2+3 gives res_lo=5.
